// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory between a load/store port (A) and a fetch port (B).
//   Round-robin grant, byte-serial little-endian access (byte i at addr+i, wrapping at 2^MEM_AW),
//   RV32 load sign/zero extension.
//   Ports: clk, rst_n (async, active low)
//     A: a_req, a_we, a_funct3, a_addr, a_wdata -> a_done, a_err, a_rdata
//     B: b_req, b_addr -> b_done, b_err, b_rdata (implicit unsigned word read)
//     memory: mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata (valid the cycle after a read)
//     busy: high whenever the FSM is not IDLE
//   Define MEM_ARB_ALIGN_CHECK_EN to reject misaligned half/word/fetch accesses as errors.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [2:0]        a_funct3,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_done,
  output logic              a_err,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_done,
  output logic              b_err,
  output logic [31:0]       b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic              port_b_q, port_b_d;
  logic              we_q, we_d;
  logic              zext_q, zext_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        idx_q, idx_d;
  logic [31:0]       res_q, res_d;
  logic              err_q, err_d;
  logic              grant_b, g_we, misaligned, illegal, done_st, unused_ok;
  logic [2:0]        g_f3;
  logic [ADDR_W-1:0] g_addr;
  logic [1:0]        cap_sel, last_sel;
  logic [31:0]       merged;
  // B wins only if A is idle or A was served last (last_b_q = 0).
  assign grant_b = b_req & (~a_req | ~last_b_q);
  assign g_we    = grant_b ? 1'b0 : a_we;
  assign g_f3    = grant_b ? 3'b010 : a_funct3;
  assign g_addr  = grant_b ? b_addr : a_addr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign misaligned = (g_f3[1:0] == 2'b01 & g_addr[0]) | (g_f3[1:0] == 2'b10 & |g_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif
  assign illegal   = (&g_f3[1:0]) | (g_we & g_f3[2]) | (g_f3 == 3'b110) | misaligned;
  assign unused_ok = ^g_addr[ADDR_W-1:MEM_AW];
  // Read data lags mem_en by one cycle, so ACCESS idx stores byte idx-1 and CAPTURE stores byte N-1.
  assign cap_sel  = idx_q[1:0] - 2'd1;
  assign last_sel = n_q[1:0] - 2'd1;
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    port_b_d = port_b_q;
    we_d     = we_q;
    zext_d   = zext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    n_d      = n_q;
    idx_d    = idx_q;
    res_d    = res_q;
    err_d    = err_q;
    merged   = res_q;
    merged[8*last_sel +: 8] = mem_rdata;
    case (state_q)
      IDLE: if (a_req || b_req) begin
        port_b_d = grant_b;
        last_b_d = grant_b;
        we_d     = g_we;
        zext_d   = g_f3[2];
        addr_d   = g_addr[MEM_AW-1:0];
        wdata_d  = grant_b ? 32'd0 : a_wdata;
        n_d      = (g_f3[1:0] == 2'b00) ? 3'd1 : (g_f3[1:0] == 2'b01) ? 3'd2 : 3'd4;
        idx_d    = 3'd0;
        res_d    = 32'd0;
        err_d    = illegal;
        state_d  = illegal ? DONE : ACCESS;
      end
      ACCESS: begin
        if (!we_q && idx_q != 3'd0) res_d[8*cap_sel +: 8] = mem_rdata;
        idx_d = idx_q + 3'd1;
        if (idx_q == n_q - 3'd1) state_d = we_q ? DONE : CAPTURE;
      end
      CAPTURE: begin
        res_d   = (n_q == 3'd1) ? {{24{~zext_q & merged[7]}}, merged[7:0]} :
                  (n_q == 3'd2) ? {{16{~zext_q & merged[15]}}, merged[15:0]} : merged;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      port_b_q <= 1'b0;
      we_q     <= 1'b0;
      zext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      n_q      <= 3'd0;
      idx_q    <= 3'd0;
      res_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      port_b_q <= port_b_d;
      we_q     <= we_d;
      zext_q   <= zext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end
  assign done_st   = state_q == DONE;
  assign a_done    = done_st & ~port_b_q;
  assign b_done    = done_st & port_b_q;
  assign a_err     = a_done & err_q;
  assign b_err     = b_done & err_q;
  assign a_rdata   = a_done ? res_q : 32'd0;
  assign b_rdata   = b_done ? res_q : 32'd0;
  assign mem_en    = state_q == ACCESS;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q + MEM_AW'(idx_q) : '0;
  assign mem_wdata = mem_we ? wdata_q[8*idx_q[1:0] +: 8] : 8'd0;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a registered-read byte memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  typedef struct packed {
    logic [1:0]  who;
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } txn_t;
  localparam logic [1:0] WHO_A = 2'b01;
  localparam logic [1:0] WHO_B = 2'b10;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [2:0]  a_funct3 = 3'd0;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
  logic        a_done, a_err;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0;
  logic [31:0] b_addr = 32'd0;
  logic        b_done, b_err;
  logic [31:0] b_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'd0;
  logic        busy;
  logic [7:0]  mem [64];
  logic [13:0] wlog [$];
  logic [5:0]  rlog [$];
  txn_t        exq [$];
  logic [13:0] wexp [$];
  int          en_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  mem_port_arbiter #(.ADDR_W(32), .MEM_AW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_funct3(a_funct3), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) if (mem_en) begin
    en_cnt <= en_cnt + 1;
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    else rlog.push_back(mem_addr);
  end

  function automatic txn_t mk(input logic [1:0] who, input logic err, input logic [31:0] rd, input int lat);
    return {who, err, rd, 8'(lat)};
  endfunction

  task automatic drive_a(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    a_we = we;
    a_funct3 = f3;
    a_addr = addr;
    a_wdata = wdata;
    a_req = 1'b1;
  endtask

  // Waits for IDLE, takes the next posedge as the grant edge, then reports the done pulse and its latency.
  task automatic wait_done(output txn_t o);
    o = '0;
    for (int g = 0; g < 20 && busy; g++) @(negedge clk);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (a_done || b_done) begin
        o = {b_done, a_done, a_err | b_err, a_rdata | b_rdata, 8'(c)};
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({a_done, a_err, b_done, b_err, mem_en, mem_we, busy} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000000", {a_done, a_err, b_done, b_err, mem_en, mem_we, busy});
    end
    vectors++;
    if ({a_rdata, b_rdata, mem_addr, mem_wdata} !== 78'd0) begin
      miscompares++;
      $display("FAIL reset_buses: got a_rdata=%h b_rdata=%h mem_addr=%h mem_wdata=%h want all 0", a_rdata, b_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    txn_t o, e;
    logic [31:0] sw = 32'hDEADBEEF;
    logic [13:0] w, got;
    wlog.delete();
    rlog.delete();
    exq.push_back(mk(WHO_A, 1'b0, 32'd0, 5));
    exq.push_back(mk(WHO_B, 1'b0, 32'hDEADBEEF, 6));
    exq.push_back(mk(WHO_A, 1'b0, 32'd0, 5));
    exq.push_back(mk(WHO_B, 1'b0, 32'hDEADBEEF, 6));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) wexp.push_back({6'(16 + i), sw[8*i +: 8]});
    drive_a(1'b1, 3'b010, 32'h10, sw);
    b_addr = 32'h10;
    b_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(o);
      e = exq.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL rr_%0d: got who=%b err=%b rdata=%h lat=%0d, want who=%b err=%b rdata=%h lat=%0d",
                 i, o.who, o.err, o.rdata, o.lat, e.who, e.err, e.rdata, e.lat);
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    while (wexp.size() != 0) begin
      w = wexp.pop_front();
      got = (wlog.size() != 0) ? wlog.pop_front() : 14'bx;
      vectors++;
      if (got !== w) begin
        miscompares++;
        $display("FAIL sw_write: got addr=%h data=%h want addr=%h data=%h", got[13:8], got[7:0], w[13:8], w[7:0]);
      end
    end
    vectors++;
    if (wlog.size() != 0) begin
      miscompares++;
      $display("FAIL sw_extra_writes: got %0d extra want 0", wlog.size());
    end
  endtask

  task automatic test_loads();
    txn_t o, e;
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads [5] = '{32'h10, 32'h10, 32'h12, 32'h12, 32'h10};
    logic [31:0] rds [5] = '{32'hFFFFFFEF, 32'h000000EF, 32'hFFFFDEAD, 32'h0000DEAD, 32'hDEADBEEF};
    int          lts [5] = '{3, 3, 4, 4, 6};
    for (int i = 0; i < 5; i++) begin
      exq.push_back(mk(WHO_A, 1'b0, rds[i], lts[i]));
      drive_a(1'b0, f3s[i], ads[i], 32'h0);
      wait_done(o);
      a_req = 1'b0;
      e = exq.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL load_f3_%b: got who=%b err=%b rdata=%h lat=%0d, want who=%b err=%b rdata=%h lat=%0d",
                 f3s[i], o.who, o.err, o.rdata, o.lat, e.who, e.err, e.rdata, e.lat);
      end
    end
  endtask

  task automatic test_wrap();
    txn_t o, e;
    int en0;
    logic [2:0]  f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h3F, 32'h0, 32'h1000_003F, 32'h1000_003F};
    logic [31:0] wds [4] = '{32'hAAAAAA34, 32'h55555585, 32'h0, 32'h0};
    wlog.delete();
    rlog.delete();
    exq.push_back(mk(WHO_A, 1'b0, 32'd0, 2));
    exq.push_back(mk(WHO_A, 1'b0, 32'd0, 2));
`ifdef MEM_ARB_ALIGN_CHECK_EN
    exq.push_back(mk(WHO_A, 1'b1, 32'd0, 1));
    exq.push_back(mk(WHO_A, 1'b1, 32'd0, 1));
`else
    exq.push_back(mk(WHO_A, 1'b0, 32'hFFFF8534, 4));
    exq.push_back(mk(WHO_A, 1'b0, 32'h00008534, 4));
`endif
    en0 = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) en0 = en_cnt;
      drive_a(i < 2, f3s[i], ads[i], wds[i]);
      wait_done(o);
      a_req = 1'b0;
      e = exq.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL wrap_%0d: got who=%b err=%b rdata=%h lat=%0d, want who=%b err=%b rdata=%h lat=%0d",
                 i, o.who, o.err, o.rdata, o.lat, e.who, e.err, e.rdata, e.lat);
      end
    end
    vectors++;
    if (wlog.size() != 2 || wlog[0] !== {6'h3F, 8'h34} || wlog[1] !== {6'h00, 8'h85}) begin
      miscompares++;
      $display("FAIL wrap_sb_writes: got %0d writes first=%h want 2 writes 3f34,0085", wlog.size(), (wlog.size() != 0) ? wlog[0] : 14'd0);
    end
`ifdef MEM_ARB_ALIGN_CHECK_EN
    vectors++;
    if (en_cnt != en0) begin
      miscompares++;
      $display("FAIL wrap_misaligned_mem_en: got %0d strobes want 0", en_cnt - en0);
    end
`else
    vectors++;
    if (rlog.size() != 4 || rlog[0] !== 6'h3F || rlog[1] !== 6'h00 || rlog[2] !== 6'h3F || rlog[3] !== 6'h00) begin
      miscompares++;
      $display("FAIL wrap_read_addrs: got %0d reads first=%h want 3f,00,3f,00", rlog.size(), (rlog.size() != 0) ? rlog[0] : 6'd0);
    end
`endif
  endtask

  task automatic test_illegal();
    txn_t o, e;
    int en0;
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b011, 3'b100, 3'b110, 3'b111};
    for (int i = 0; i < 4; i++) begin
      exq.push_back(mk(WHO_A, 1'b1, 32'd0, 1));
      en0 = en_cnt;
      drive_a(wes[i], f3s[i], 32'h10, 32'h12345678);
      wait_done(o);
      a_req = 1'b0;
      e = exq.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL illegal_we%b_f3_%b: got who=%b err=%b rdata=%h lat=%0d, want who=%b err=%b rdata=%h lat=%0d",
                 wes[i], f3s[i], o.who, o.err, o.rdata, o.lat, e.who, e.err, e.rdata, e.lat);
      end
      vectors++;
      if (en_cnt != en0) begin
        miscompares++;
        $display("FAIL illegal_mem_en_%0d: got %0d strobes want 0", i, en_cnt - en0);
      end
    end
  endtask

  task automatic test_reset_mid();
    txn_t o, e;
    logic saw_done = 1'b0;
    for (int g = 0; g < 20 && busy; g++) @(negedge clk);
    drive_a(1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_access: got mem_en=%b want 1", mem_en);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_en, mem_we, busy, a_done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_abort: got en/we/busy/done=%b want 0000", {mem_en, mem_we, busy, a_done});
    end
    a_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      saw_done = saw_done | a_done;
    end
    rst_n = 1'b1;
    @(negedge clk);
    saw_done = saw_done | a_done;
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_no_done: got a_done seen=%b want 0", saw_done);
    end
    exq.push_back(mk(WHO_A, 1'b0, 32'hDEADBEEF, 6));
    exq.push_back(mk(WHO_B, 1'b0, 32'hDEADBEEF, 6));
    drive_a(1'b0, 3'b010, 32'h10, 32'h0);
    b_addr = 32'h10;
    b_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_done(o);
      if (i == 0) a_req = 1'b0;
      else b_req = 1'b0;
      e = exq.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midrst_after_%0d: got who=%b err=%b rdata=%h lat=%0d, want who=%b err=%b rdata=%h lat=%0d",
                 i, o.who, o.err, o.rdata, o.lat, e.who, e.err, e.rdata, e.lat);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_loads();
    test_wrap();
    test_illegal();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide data memory between two requesters: port A (load/store unit) and port B (instruction fetch).
- Arbitrates between the two ports round-robin.
- Splits each byte/half/word access into sequential one-byte memory cycles, little-endian (byte i at addr+i).
- Assembles load data with RV32 sign/zero extension per funct3.

Parameters:
- ADDR_W, 32, requester address width.
- MEM_AW, 6, memory byte-address width; addresses are truncated to the low MEM_AW bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  port A request; hold with fields stable until a_done
- a_we  in  1  1 = store, 0 = load
- a_funct3  in  3  RV32 LOAD/STORE funct3
- a_addr  in  ADDR_W  byte address
- a_wdata  in  32  store data; low bytes used
- a_done  out  1  one-cycle completion pulse
- a_err  out  1  valid with a_done; illegal funct3 or misalignment
- a_rdata  out  32  load result; valid with a_done
- b_req  in  1  fetch request (implicit 32-bit unsigned read)
- b_addr  in  ADDR_W  fetch byte address
- b_done  out  1  completion pulse
- b_err  out  1  valid with b_done
- b_rdata  out  32  instruction word
- mem_en  out  1  memory byte access strobe
- mem_we  out  1  byte write enable
- mem_addr  out  MEM_AW  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, registered in memory: valid the cycle after mem_en with mem_we = 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: async on rst_n low.
  - State goes to IDLE; all outputs 0.
  - last_grant = B, so A wins the first tie.
  - Reset mid-transaction aborts it: no done pulse, mem_en/mem_we drop immediately.
- FSM states: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - Only one req high: grant that port.
  - Both high: grant the port not in last_grant.
  - On grant: latch port id, we, funct3, addr, wdata; set N and idx = 0; update last_grant.
  - N = 1 for funct3[1:0] = 00, 2 for 01, 4 for 10.
  - Fetch: N = 4, load, unsigned.
- Illegal request goes directly IDLE -> DONE with err = 1, rdata = 0, and no mem_en. Illegal means:
  - funct3[1:0] = 11;
  - a_we = 1 with funct3[2] = 1;
  - funct3 = 110.
- ACCESS, one byte per cycle:
  - mem_en = 1; mem_addr = (addr + idx) mod 2^MEM_AW, wrapping past the top byte; mem_we = we; mem_wdata = wdata[8*idx+7:8*idx].
  - On reads, mem_rdata for byte idx-1 is captured into result byte idx-1 on the same edge.
  - Leaves after idx = N-1: loads go to CAPTURE, stores go to DONE.
- CAPTURE: mem_en = 0; last byte captured; extension applied.
  - funct3[2] = 0: sign-extend from bit 8N-1.
  - funct3[2] = 1: zero-extend.
- DONE:
  - The granted port's done = 1 for exactly one cycle, with rdata and err driven. rdata = 0 for stores.
  - The other port's outputs stay 0. Next state is IDLE.
- Latency, counted from the IDLE edge that grants:
  - Loads: done visible N+2 cycles later.
  - Stores: done visible N+1 cycles later.
  - Illegal requests: done visible 1 cycle later.
- Requests are sampled only in IDLE, so one idle cycle always separates transactions.
  - A req still high in the DONE cycle is treated as a new request.
  - A req dropped after grant does not cancel; done still pulses.
- Memory access is at most one byte per cycle; mem_en is never asserted in IDLE or DONE.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Defined: a misaligned access is treated as illegal (err = 1, no mem_en, done 1 cycle after grant). Misaligned means:
  - half with addr[0] = 1;
  - word or fetch with addr[1:0] != 00.
- Undefined: misaligned accesses proceed byte-wise with address wrap; err flags only illegal funct3.

Test Plan:
- SW: a_addr 0x10, a_wdata 0xDEADBEEF -> mem bytes 0x10..0x13 written EF, BE, AD, DE on consecutive cycles; a_done 5 cycles after grant; a_err 0.
- LB and LBU at address 0x10 (holding byte 0xEF) -> LB gives a_rdata 0xFFFFFFEF, LBU gives 0x000000EF; done 3 cycles after grant each.
- a_req and b_req both high from reset -> A served first. With both held high, the following grants alternate B, A, B; b_rdata 0xDEADBEEF from 0x10 at done 6 cycles after its grant.
- LH at 0x3F with MEM_AW = 6 and macro undefined -> bytes read from 0x3F then 0x00; sign-extended result. With the macro defined -> a_err = 1, no mem_en, done 1 cycle after grant.
- a_funct3 = 011 load, or store with funct3 = 100 -> a_err = 1, a_rdata 0, mem_en never high.
- rst_n pulsed low during ACCESS of an LW -> mem_en drops immediately; no a_done; busy 0; next request is serviced normally.
